// File: rtl/keypoint_hessian_gen.sv
// Producer for the SIFT low-contrast detector. Loads a 3x3x3 DoG neighbourhood
// serially, then computes the centre value, first derivatives, the Hessian
// adjugate and its determinant across three register stages.
module keypoint_hessian_gen #(
    parameter int unsigned ADJ_SHIFT = 8,
    parameter int unsigned DET_SHIFT = 10
) (
    input  logic               iclk,
    input  logic               irst_n,
    input  logic               isample_valid,
    input  logic signed [8:0]  isample,
    output logic               osample_ready,
    output logic signed [8:0]  opixel_data,
    output logic signed [8:0]  oadj11,
    output logic signed [8:0]  oadj12,
    output logic signed [8:0]  oadj13,
    output logic signed [8:0]  oadj21,
    output logic signed [8:0]  oadj22,
    output logic signed [8:0]  oadj23,
    output logic signed [8:0]  oadj31,
    output logic signed [8:0]  oadj32,
    output logic signed [8:0]  oadj33,
    output logic signed [16:0] odet,
    output logic signed [8:0]  odx,
    output logic signed [8:0]  ody,
    output logic signed [8:0]  ods,
    output logic               ovalid,
    input  logic               iready
);

    typedef enum logic [2:0] {StLoad, StHess, StMinor, StDet, StOut} state_e;

    function automatic logic signed [8:0] sat9(input logic signed [31:0] v);
        if (v > 32'sd255) return 9'h0ff;
        else if (v < -32'sd256) return 9'h100;
        else return v[8:0];
    endfunction

    function automatic logic signed [16:0] sat17(input logic signed [31:0] v);
        if (v > 32'sd65535) return 17'h0ffff;
        else if (v < -32'sd65536) return 17'h10000;
        else return v[16:0];
    endfunction

    function automatic logic signed [10:0] sx11(input logic signed [8:0] v);
        return 11'(v);
    endfunction

    state_e state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic signed [8:0] samp_q [27];
    logic signed [8:0] samp_d [27];

    // Stage 1: clamped Hessian entries and derivatives
    logic signed [8:0] h11_q, h22_q, h33_q, h12_q, h13_q, h23_q;
    logic signed [8:0] h11_d, h22_d, h33_d, h12_d, h13_d, h23_d;
    logic signed [8:0] dx_q, dy_q, ds_q, dx_d, dy_d, ds_d;
    logic signed [10:0] h11_w, h22_w, h33_w, h12_w, h13_w, h23_w, dx_w, dy_w, ds_w;
    // Stage 2: full-precision minors (|a| <= 130816 fits 20 bits signed)
    logic signed [19:0] a11_q, a22_q, a33_q, a12_q, a13_q, a23_q;
    logic signed [19:0] a11_d, a22_d, a33_d, a12_d, a13_d, a23_d;
    // Stage 3: output registers
    logic signed [8:0] pix_q, odx_q, ody_q, ods_q, adj11_q, adj22_q, adj33_q;
    logic signed [8:0] adj12_q, adj13_q, adj23_q;
    logic signed [8:0] pix_d, odx_d, ody_d, ods_d, adj11_d, adj22_d, adj33_d;
    logic signed [8:0] adj12_d, adj13_d, adj23_d;
    logic signed [16:0] det_q, det_d;
    logic signed [31:0] det_w;

    // Sequencer: serial load, three compute stages, then hold until handshake
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        samp_d  = samp_q;
        unique case (state_q)
            StLoad: begin
                if (isample_valid) begin
                    samp_d[cnt_q] = isample;
                    if (cnt_q == 5'd26) begin
                        cnt_d   = 5'd0;
                        state_d = StHess;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            StHess:  state_d = StMinor;
            StMinor: state_d = StDet;
            StDet:   state_d = StOut;
            StOut:   if (iready) state_d = StLoad;
            default: state_d = StLoad;
        endcase
    end

    assign osample_ready = (state_q == StLoad);
    assign ovalid        = (state_q == StOut);

    // Datapath: each stage register only loads in its own state
    always_comb begin
        h11_w = sx11(samp_q[14]) + sx11(samp_q[12]) - (sx11(samp_q[13]) <<< 1);
        h22_w = sx11(samp_q[16]) + sx11(samp_q[10]) - (sx11(samp_q[13]) <<< 1);
        h33_w = sx11(samp_q[22]) + sx11(samp_q[4]) - (sx11(samp_q[13]) <<< 1);
        h12_w = (sx11(samp_q[17]) - sx11(samp_q[15]) - sx11(samp_q[11]) + sx11(samp_q[9])) >>> 2;
        h13_w = (sx11(samp_q[23]) - sx11(samp_q[21]) - sx11(samp_q[5]) + sx11(samp_q[3])) >>> 2;
        h23_w = (sx11(samp_q[25]) - sx11(samp_q[19]) - sx11(samp_q[7]) + sx11(samp_q[1])) >>> 2;
        dx_w  = (sx11(samp_q[14]) - sx11(samp_q[12])) >>> 1;
        dy_w  = (sx11(samp_q[16]) - sx11(samp_q[10])) >>> 1;
        ds_w  = (sx11(samp_q[22]) - sx11(samp_q[4])) >>> 1;
        det_w = 32'(h11_q) * 32'(a11_q) + 32'(h12_q) * 32'(a12_q) + 32'(h13_q) * 32'(a13_q);

        {h11_d, h22_d, h33_d, h12_d, h13_d, h23_d} = {h11_q, h22_q, h33_q, h12_q, h13_q, h23_q};
        {dx_d, dy_d, ds_d} = {dx_q, dy_q, ds_q};
        {a11_d, a22_d, a33_d, a12_d, a13_d, a23_d} = {a11_q, a22_q, a33_q, a12_q, a13_q, a23_q};
        {pix_d, odx_d, ody_d, ods_d} = {pix_q, odx_q, ody_q, ods_q};
        {adj11_d, adj22_d, adj33_d, adj12_d, adj13_d, adj23_d} =
            {adj11_q, adj22_q, adj33_q, adj12_q, adj13_q, adj23_q};
        det_d = det_q;

        if (state_q == StHess) begin
            h11_d = sat9(32'(h11_w));
            h22_d = sat9(32'(h22_w));
            h33_d = sat9(32'(h33_w));
            h12_d = sat9(32'(h12_w));
            h13_d = sat9(32'(h13_w));
            h23_d = sat9(32'(h23_w));
            dx_d  = dx_w[8:0];
            dy_d  = dy_w[8:0];
            ds_d  = ds_w[8:0];
        end
        if (state_q == StMinor) begin
            a11_d = 20'(h22_q) * 20'(h33_q) - 20'(h23_q) * 20'(h23_q);
            a22_d = 20'(h11_q) * 20'(h33_q) - 20'(h13_q) * 20'(h13_q);
            a33_d = 20'(h11_q) * 20'(h22_q) - 20'(h12_q) * 20'(h12_q);
            a12_d = 20'(h13_q) * 20'(h23_q) - 20'(h12_q) * 20'(h33_q);
            a13_d = 20'(h12_q) * 20'(h23_q) - 20'(h13_q) * 20'(h22_q);
            a23_d = 20'(h12_q) * 20'(h13_q) - 20'(h11_q) * 20'(h23_q);
        end
        if (state_q == StDet) begin
            // Centre sample is captured here so a new load cannot disturb it
            pix_d   = samp_q[13];
            odx_d   = dx_q;
            ody_d   = dy_q;
            ods_d   = ds_q;
            adj11_d = sat9(32'(a11_q) >>> ADJ_SHIFT);
            adj22_d = sat9(32'(a22_q) >>> ADJ_SHIFT);
            adj33_d = sat9(32'(a33_q) >>> ADJ_SHIFT);
            adj12_d = sat9(32'(a12_q) >>> ADJ_SHIFT);
            adj13_d = sat9(32'(a13_q) >>> ADJ_SHIFT);
            adj23_d = sat9(32'(a23_q) >>> ADJ_SHIFT);
            det_d   = sat17(det_w >>> DET_SHIFT);
        end
    end

    // Control and result registers with synchronous reset
    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            state_q <= StLoad;
            cnt_q   <= 5'd0;
            {h11_q, h22_q, h33_q, h12_q, h13_q, h23_q} <= '0;
            {dx_q, dy_q, ds_q} <= '0;
            {a11_q, a22_q, a33_q, a12_q, a13_q, a23_q} <= '0;
            {pix_q, odx_q, ody_q, ods_q} <= '0;
            {adj11_q, adj22_q, adj33_q, adj12_q, adj13_q, adj23_q} <= '0;
            det_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            {h11_q, h22_q, h33_q, h12_q, h13_q, h23_q} <= {h11_d, h22_d, h33_d, h12_d, h13_d, h23_d};
            {dx_q, dy_q, ds_q} <= {dx_d, dy_d, ds_d};
            {a11_q, a22_q, a33_q, a12_q, a13_q, a23_q} <= {a11_d, a22_d, a33_d, a12_d, a13_d, a23_d};
            {pix_q, odx_q, ody_q, ods_q} <= {pix_d, odx_d, ody_d, ods_d};
            {adj11_q, adj22_q, adj33_q, adj12_q, adj13_q, adj23_q} <=
                {adj11_d, adj22_d, adj33_d, adj12_d, adj13_d, adj23_d};
            det_q <= det_d;
        end
    end

    // Sample slots need no reset: every slot is rewritten before it is used
    always_ff @(posedge iclk) begin
        samp_q <= samp_d;
    end

    assign opixel_data = pix_q;
    assign odx    = odx_q;
    assign ody    = ody_q;
    assign ods    = ods_q;
    assign oadj11 = adj11_q;
    assign oadj12 = adj12_q;
    assign oadj13 = adj13_q;
    assign oadj21 = adj12_q;
    assign oadj22 = adj22_q;
    assign oadj23 = adj23_q;
    assign oadj31 = adj13_q;
    assign oadj32 = adj23_q;
    assign oadj33 = adj33_q;
    assign odet   = det_q;

endmodule

// File: tb/tb_keypoint_hessian_gen.sv
// Directed bench for keypoint_hessian_gen with hand-computed expected results.
module tb_keypoint_hessian_gen;

    logic               iclk = 1'b0;
    logic               irst_n;
    logic               isample_valid;
    logic signed [8:0]  isample;
    logic               osample_ready;
    logic signed [8:0]  opixel_data;
    logic signed [8:0]  oadj11, oadj12, oadj13, oadj21, oadj22, oadj23, oadj31, oadj32, oadj33;
    logic signed [16:0] odet;
    logic signed [8:0]  odx, ody, ods;
    logic               ovalid;
    logic               iready;

    int n_cmp = 0;
    int n_err = 0;
    logic signed [8:0] vec [27];

    always #5 iclk = ~iclk;

    keypoint_hessian_gen #(.ADJ_SHIFT(8), .DET_SHIFT(10)) dut (
        .iclk(iclk), .irst_n(irst_n), .isample_valid(isample_valid), .isample(isample),
        .osample_ready(osample_ready), .opixel_data(opixel_data),
        .oadj11(oadj11), .oadj12(oadj12), .oadj13(oadj13),
        .oadj21(oadj21), .oadj22(oadj22), .oadj23(oadj23),
        .oadj31(oadj31), .oadj32(oadj32), .oadj33(oadj33),
        .odet(odet), .odx(odx), .ody(ody), .ods(ods),
        .ovalid(ovalid), .iready(iready)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_vec();
        for (int k = 0; k < 27; k++) vec[k] = '0;
    endtask

    task automatic stream_vec();
        for (int k = 0; k < 27; k++) begin
            isample_valid = 1'b1;
            isample       = vec[k];
            @(posedge iclk);
            #1;
        end
        isample_valid = 1'b0;
        isample       = '0;
    endtask

    // Called just after edge E; ovalid must rise at exactly E+3
    task automatic wait_result(input string tag);
        int lat = 0;
        while (!ovalid && lat < 10) begin
            @(posedge iclk);
            #1;
            lat++;
        end
        check_val({tag, ":latency"}, lat, 3);
    endtask

    task automatic check_result(input string tag, input int pix, input int dx, input int dy,
                                input int ds, input int a11, input int a12, input int a13,
                                input int a22, input int a23, input int a33, input int det);
        check_val({tag, ":pix"}, 32'(opixel_data), pix);
        check_val({tag, ":dx"}, 32'(odx), dx);
        check_val({tag, ":dy"}, 32'(ody), dy);
        check_val({tag, ":ds"}, 32'(ods), ds);
        check_val({tag, ":adj11"}, 32'(oadj11), a11);
        check_val({tag, ":adj12"}, 32'(oadj12), a12);
        check_val({tag, ":adj13"}, 32'(oadj13), a13);
        check_val({tag, ":adj21"}, 32'(oadj21), a12);
        check_val({tag, ":adj22"}, 32'(oadj22), a22);
        check_val({tag, ":adj23"}, 32'(oadj23), a23);
        check_val({tag, ":adj31"}, 32'(oadj31), a13);
        check_val({tag, ":adj32"}, 32'(oadj32), a23);
        check_val({tag, ":adj33"}, 32'(oadj33), a33);
        check_val({tag, ":det"}, 32'(odet), det);
    endtask

    task automatic handshake(input string tag);
        iready = 1'b1;
        @(posedge iclk);
        #1;
        iready = 1'b0;
        check_val({tag, ":hs_valid"}, 32'(ovalid), 0);
        check_val({tag, ":hs_ready"}, 32'(osample_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        irst_n = 1'b0;
        isample_valid = 1'b0;
        isample = '0;
        iready = 1'b0;
        repeat (2) @(posedge iclk);
        #1;
        check_val("rst:ready", 32'(osample_ready), 1);
        check_val("rst:valid", 32'(ovalid), 0);
        check_val("rst:pix", 32'(opixel_data), 0);
        check_val("rst:det", 32'(odet), 0);
        check_val("rst:adj11", 32'(oadj11), 0);
        irst_n = 1'b1;

        // All zero
        clear_vec();
        stream_vec();
        wait_result("zero");
        check_result("zero", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        handshake("zero");

        // Centre only: h diag = -200, adj diag = 40000>>>8, det = -8000000>>>10 (floor)
        clear_vec();
        vec[13] = 9'sd100;
        stream_vec();
        wait_result("ctr");
        check_result("ctr", 100, 0, 0, 0, 156, 0, 0, 156, 0, 156, -7813);
        handshake("ctr");

        // Pure x gradient
        clear_vec();
        vec[14] = 9'sd100;
        vec[12] = -9'sd100;
        stream_vec();
        wait_result("dx");
        check_result("dx", 0, 100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        handshake("dx");

        // Floor checks: dx = -3>>>1 = -2; h11=3, h12=2 -> a33 = -4, -4>>>8 = -1
        clear_vec();
        vec[12] = 9'sd3;
        vec[9]  = 9'sd4;
        vec[17] = 9'sd4;
        stream_vec();
        wait_result("mix");
        check_result("mix", 0, -2, 0, 0, 0, 0, 0, 0, 0, -1, 0);
        handshake("mix");

        // Saturation: diag h clamps to 255; adj = 65025>>>8; det = 255*65025 = 16581375>>>10
        clear_vec();
        vec[14] = 9'sd255;
        vec[12] = 9'sd255;
        vec[13] = 9'h100;
        stream_vec();
        wait_result("sat");
        check_result("sat", -256, 0, 0, 0, 254, 0, 0, 254, 0, 254, 16192);

        // Backpressure with toggling sample strobe; nothing may be loaded
        for (int i = 0; i < 5; i++) begin
            isample_valid = i[0];
            isample = 9'(i * 37 + 5);
            @(posedge iclk);
            #1;
            check_val("bp:valid", 32'(ovalid), 1);
            check_val("bp:ready", 32'(osample_ready), 0);
            check_val("bp:det", 32'(odet), 16192);
            check_val("bp:adj11", 32'(oadj11), 254);
        end
        // Sample presented in the handshake cycle must be ignored
        isample_valid = 1'b1;
        isample = 9'sd77;
        iready = 1'b1;
        @(posedge iclk);
        #1;
        iready = 1'b0;
        isample_valid = 1'b0;
        check_val("bp:hs_valid", 32'(ovalid), 0);
        check_val("bp:hs_ready", 32'(osample_ready), 1);
        check_val("bp:held_det", 32'(odet), 16192);
        clear_vec();
        vec[14] = 9'sd100;
        vec[12] = -9'sd100;
        stream_vec();
        wait_result("bp2");
        check_result("bp2", 0, 100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        handshake("bp2");

        // Reset mid-load discards the partial set
        for (int i = 0; i < 10; i++) begin
            isample_valid = 1'b1;
            isample = 9'($urandom);
            @(posedge iclk);
            #1;
        end
        isample_valid = 1'b0;
        irst_n = 1'b0;
        @(posedge iclk);
        #1;
        irst_n = 1'b1;
        check_val("mrst:ready", 32'(osample_ready), 1);
        check_val("mrst:valid", 32'(ovalid), 0);
        check_val("mrst:det", 32'(odet), 0);
        clear_vec();
        vec[13] = 9'sd100;
        stream_vec();
        wait_result("mrst");
        check_result("mrst", 100, 0, 0, 0, 156, 0, 0, 156, 0, 156, -7813);
        handshake("mrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
